// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with a per-frame shadow
// capture, blanking, decimal points, leading-zero suppression, freeze and PWM.
module sevenseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned PRESCALE_LOG2 = 16
) (
  input  logic                    clk_core,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  input  logic                    i_lz_suppress,
  input  logic                    i_freeze,
  input  logic [3:0]              i_brightness,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [PRESCALE_LOG2-1:0] presc;
  logic [IDX_W-1:0]         idx;
  logic [VAL_W-1:0]         shadow_val;
  logic [NUM_DIGITS-1:0]    shadow_dp;
  logic [NUM_DIGITS-1:0]    shadow_blank;

  logic                     tick;
  logic                     cap;
  logic                     on;
  logic [NUM_DIGITS-1:0]    suppressed;
  logic [NUM_DIGITS-1:0]    dark;
  logic [3:0]               cur_nib;
  logic                     cur_dp;
  logic                     cur_dark;
  logic [NUM_DIGITS-1:0]    an_nxt;
  logic [6:0]               seg_nxt;
  logic                     dp_nxt;
  logic                     frame_nxt;

  // Dwell tick and end-of-frame capture strobe
  always_comb begin
    tick = &presc;
    cap  = tick && (idx == LAST_IDX);
  end

  // Free-running prescaler and digit index (wraps at NUM_DIGITS, not a power of 2)
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + PRESCALE_LOG2'(1);
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // Shadow capture once per frame so mid-frame input changes never tear
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
    end else if (cap && !i_freeze) begin
      shadow_val   <= i_value;
      shadow_dp    <= i_dp;
      shadow_blank <= i_blank;
    end
  end

  // Leading-zero suppression: digit i dark when it and every digit above are zero
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    suppressed = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run      = zero_run && (shadow_val[4*i +: 4] == 4'h0);
      suppressed[i] = (i != 0) && i_lz_suppress && zero_run;
    end
    dark = shadow_blank | suppressed;
  end

  // Select the shadow fields of the digit currently being scanned
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib  = shadow_val[4*i +: 4];
        cur_dp   = shadow_dp[i];
        cur_dark = dark[i];
      end
    end
  end

  // PWM on-window, anode pattern, segment decode and frame marker
  always_comb begin
    on        = (presc[PRESCALE_LOG2-1 -: 4] <= i_brightness);
    an_nxt    = '1;
    seg_nxt   = 7'h7F;
    dp_nxt    = 1'b1;
    frame_nxt = (idx == '0) && (presc == '0);
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if ((idx == IDX_W'(i)) && on && !cur_dark) begin
        an_nxt[i] = 1'b0;
      end
    end
    if (!cur_dark) begin
      dp_nxt = !cur_dp;
      unique case (cur_nib)
        4'h0: seg_nxt = 7'h01;
        4'h1: seg_nxt = 7'h4F;
        4'h2: seg_nxt = 7'h12;
        4'h3: seg_nxt = 7'h06;
        4'h4: seg_nxt = 7'h4C;
        4'h5: seg_nxt = 7'h24;
        4'h6: seg_nxt = 7'h20;
        4'h7: seg_nxt = 7'h0F;
        4'h8: seg_nxt = 7'h00;
        4'h9: seg_nxt = 7'h04;
        4'hA: seg_nxt = 7'h08;
        4'hB: seg_nxt = 7'h60;
        4'hC: seg_nxt = 7'h31;
        4'hD: seg_nxt = 7'h42;
        4'hE: seg_nxt = 7'h30;
        4'hF: seg_nxt = 7'h38;
        default: seg_nxt = 7'h7F;
      endcase
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk_core or negedge rstn) begin
    if (!rstn) begin
      o_an    <= '1;
      o_seg   <= 7'h7F;
      o_dp    <= 1'b1;
      o_frame <= 1'b0;
    end else begin
      o_an    <= an_nxt;
      o_seg   <= seg_nxt;
      o_dp    <= dp_nxt;
      o_frame <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl: 8-digit and 5-digit instances, PRESCALE_LOG2=4.
module tb_sevenseg_scan_ctrl;

  logic        clk_core = 1'b0;
  logic        rstn;
  logic [31:0] i_value;
  logic [7:0]  i_dp;
  logic [7:0]  i_blank;
  logic        i_lz_suppress;
  logic        i_freeze;
  logic [3:0]  i_brightness;

  logic [31:0] nxt_value;
  logic [7:0]  nxt_dp;
  logic [7:0]  nxt_blank;
  logic        nxt_freeze;

  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;
  logic        o_frame;

  logic [19:0] value5;
  logic [4:0]  dp5;
  logic [4:0]  blank5;
  logic [4:0]  o_an5;
  logic [6:0]  o_seg5;
  logic        o_dp5;
  logic        o_frame5;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt     = 0;
  bit chk5    = 1'b1;

  // 5-digit digit codes for nibbles D,C,B,A,4 (digit 4 in the top field)
  logic [34:0] segs5 = {7'h4C, 7'h08, 7'h60, 7'h31, 7'h42};

  assign value5 = i_value[19:0];
  assign dp5    = i_dp[4:0];
  assign blank5 = i_blank[4:0];

  always #5 clk_core = ~clk_core;

  sevenseg_scan_ctrl #(.NUM_DIGITS(8), .PRESCALE_LOG2(4)) u_dut (
    .clk_core      (clk_core),
    .rstn          (rstn),
    .i_value       (i_value),
    .i_dp          (i_dp),
    .i_blank       (i_blank),
    .i_lz_suppress (i_lz_suppress),
    .i_freeze      (i_freeze),
    .i_brightness  (i_brightness),
    .o_an          (o_an),
    .o_seg         (o_seg),
    .o_dp          (o_dp),
    .o_frame       (o_frame)
  );

  sevenseg_scan_ctrl #(.NUM_DIGITS(5), .PRESCALE_LOG2(4)) u_dut5 (
    .clk_core      (clk_core),
    .rstn          (rstn),
    .i_value       (value5),
    .i_dp          (dp5),
    .i_blank       (blank5),
    .i_lz_suppress (i_lz_suppress),
    .i_freeze      (i_freeze),
    .i_brightness  (i_brightness),
    .o_an          (o_an5),
    .o_seg         (o_seg5),
    .o_dp          (o_dp5),
    .o_frame       (o_frame5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @c=%0d: got %h, expected %h", tag, cnt - 1, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    @(negedge clk_core);
    cnt++;
  endtask

  // One 128-cycle frame; shadowed inputs switch to nxt_* halfway through.
  task automatic run_frame(input logic [7:0] lit, input logic [55:0] segs, input logic [7:0] dps);
    int c, d, p, d5;
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    logic [4:0] ea5;
    logic [6:0] es5;
    for (int k = 0; k < 128; k++) begin
      if (k == 64) begin
        i_value  = nxt_value;
        i_dp     = nxt_dp;
        i_blank  = nxt_blank;
        i_freeze = nxt_freeze;
      end
      step();
      c  = cnt - 1;
      d  = (c / 16) % 8;
      p  = c % 16;
      ea = 8'hFF;
      if (lit[d] && (p <= int'(i_brightness))) ea[d] = 1'b0;
      es = lit[d] ? segs[7*d +: 7] : 7'h7F;
      ed = lit[d] ? ~dps[d] : 1'b1;
      check("an",     32'(o_an),     32'(ea));
      check("seg",    32'(o_seg),    32'(es));
      check("dp",     32'(o_dp),     32'(ed));
      check("frame",  32'(o_frame),  32'((c % 128) == 0));
      check("frame5", 32'(o_frame5), 32'((c % 80) == 0));
      if (chk5 && c < 160) begin
        if (c < 80) begin
          ea5 = 5'h1F;
          es5 = 7'h7F;
        end else begin
          d5  = (c - 80) / 16;
          ea5 = ~(5'(1) << d5);
          es5 = segs5[7*d5 +: 7];
        end
        check("an5",  32'(o_an5),  32'(ea5));
        check("seg5", 32'(o_seg5), 32'(es5));
      end
    end
  endtask

  initial begin
    rstn          = 1'b0;
    i_value       = 32'h1234ABCD;
    i_dp          = 8'h00;
    i_blank       = 8'h00;
    i_lz_suppress = 1'b0;
    i_freeze      = 1'b0;
    i_brightness  = 4'd15;
    nxt_value     = 32'h1234ABCD;
    nxt_dp        = 8'h00;
    nxt_blank     = 8'h00;
    nxt_freeze    = 1'b0;

    repeat (3) @(negedge clk_core);
    check("rst_an",    32'(o_an),    32'h0FF);
    check("rst_seg",   32'(o_seg),   32'h07F);
    check("rst_dp",    32'(o_dp),    32'h1);
    check("rst_frame", 32'(o_frame), 32'h0);
    check("rst_an5",   32'(o_an5),   32'h1F);
    rstn = 1'b1;
    cnt  = 0;

    // Frame 0: fully dark after reset
    run_frame(8'h00, 56'h0, 8'h00);

    // Frame 1: scan order of 1234ABCD
    nxt_value = 32'h00000050;
    run_frame(8'hFF, {7'h4F, 7'h12, 7'h06, 7'h4C, 7'h08, 7'h60, 7'h31, 7'h42}, 8'h00);

    // Frame 2: 00000050 with leading-zero suppression
    i_lz_suppress = 1'b1;
    nxt_value     = 32'h00000000;
    run_frame(8'h03, {{6{7'h7F}}, 7'h24, 7'h01}, 8'h00);

    // Frame 3: all-zero value, only digit 0 lit
    run_frame(8'h01, {{7{7'h7F}}, 7'h01}, 8'h00);

    // Frame 4: suppression off, every digit shows 0
    i_lz_suppress = 1'b0;
    nxt_value     = 32'h76543210;
    nxt_blank     = 8'h02;
    nxt_dp        = 8'h01;
    run_frame(8'hFF, {8{7'h01}}, 8'h00);

    // Frame 5: 76543210, digit 1 blanked, dp on digit 0, brightness 3; freeze requested
    i_brightness = 4'd3;
    nxt_value    = 32'hFEDCBA98;
    nxt_blank    = 8'h00;
    nxt_dp       = 8'h00;
    nxt_freeze   = 1'b1;
    run_frame(8'hFD, {7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01}, 8'h01);

    // Frame 6: frozen contents, brightness 0; freeze released
    i_brightness = 4'd0;
    nxt_freeze   = 1'b0;
    run_frame(8'hFD, {7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01}, 8'h01);

    // Frame 7: FEDCBA98 after unfreeze, full brightness
    i_brightness = 4'd15;
    run_frame(8'hFF, {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00}, 8'h00);

    // Reset in the middle of digit 2 of frame 8
    repeat (37) step();
    check("pre_rst_an",  32'(o_an),  32'h0FB);
    check("pre_rst_seg", 32'(o_seg), 32'h008);
    rstn = 1'b0;
    #1;
    check("mid_rst_an",    32'(o_an),    32'h0FF);
    check("mid_rst_seg",   32'(o_seg),   32'h07F);
    check("mid_rst_dp",    32'(o_dp),    32'h1);
    check("mid_rst_frame", 32'(o_frame), 32'h0);
    check("mid_rst_an5",   32'(o_an5),   32'h1F);
    repeat (2) @(negedge clk_core);
    rstn = 1'b1;
    cnt  = 0;
    chk5 = 1'b0;

    // First frame after the mid-frame reset is dark again
    run_frame(8'h00, 56'h0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Parametrised, time-multiplexed seven-segment display controller for the Nexys A7 toplevel. It replaces ad-hoc per-counter digit scanning with a single reusable block. The block scans NUM_DIGITS common-anode digits from a hex nibble vector and latches that vector tear-free once per frame. It adds per-digit blanking, decimal points, leading-zero suppression, a freeze mode and PWM brightness. It runs in the clk_core domain and drives the board anode and cathode pins directly.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16).
PRESCALE_LOG2, 16, dwell per digit is 2^PRESCALE_LOG2 clk_core cycles (must be >= 4).

Ports:
clk_core  in  1  core clock.
rstn  in  1  reset, asynchronous, active-low.
i_value  in  4*NUM_DIGITS  hex nibbles; nibble i is shown on digit i; digit 0 is rightmost/least significant.
i_dp  in  NUM_DIGITS  decimal point request per digit, active-high.
i_blank  in  NUM_DIGITS  force digit dark, active-high.
i_lz_suppress  in  1  enable leading-zero suppression.
i_freeze  in  1  hold the current shadow contents.
i_brightness  in  4  on-time in 16ths of dwell, minus 1 (15 = full).
o_an  out  NUM_DIGITS  anodes, active-low, registered.
o_seg  out  7  cathodes a..g, active-low, registered; o_seg[6]=a ... o_seg[0]=g.
o_dp  out  1  decimal point cathode, active-low, registered.
o_frame  out  1  one-cycle pulse, registered; high in the first output cycle of digit 0.

Behaviour:
- State: presc (PRESCALE_LOG2 bits, free-running, wraps to 0); idx (0..NUM_DIGITS-1).
- tick = (presc == all-ones). On tick, idx increments; it wraps to 0 after NUM_DIGITS-1 (not at a power of 2).
- Capture:
  - cap = tick && idx == NUM_DIGITS-1, i.e. the last cycle of a frame.
  - On cap with i_freeze==0: shadow_val <= i_value, shadow_dp <= i_dp, shadow_blank <= i_blank.
  - On cap with i_freeze==1: shadow registers hold.
  - i_freeze is sampled only at cap.
  - Input changes mid-frame are never visible before the next frame, so there is no tearing.
- Leading-zero suppression: digit i (i >= 1) is suppressed when i_lz_suppress==1 AND shadow nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never suppressed. i_lz_suppress is used combinationally, not shadowed.
- dark(i) = shadow_blank[i] OR suppressed(i).
- Brightness: on = (presc[PRESCALE_LOG2-1 -: 4] <= i_brightness). It is compared combinationally, so changes take effect at the next clock.
- Output register update, every cycle, from current state (1-cycle latency):
  - o_an: all ones, except bit idx driven 0 when on && !dark(idx).
  - o_seg: decode(shadow nibble idx) when !dark(idx), else 7'h7F.
  - o_dp: !shadow_dp[idx] when !dark(idx), else 1.
  - o_frame: 1 when idx==0 && presc==0, else 0.
- Only one anode is ever low. Anode is high during the off portion of the dwell and for dark digits.
- Decode (hex nibble -> o_seg, 7-bit hex value):
  - 0:01, 1:4F, 2:12, 3:06, 4:4C, 5:24, 6:20, 7:0F
  - 8:00, 9:04, A:08, b:60, C:31, d:42, E:30, F:38
- Reset values, applied asynchronously while rstn=0:
  - presc=0, idx=0, shadow_val=0, shadow_dp=0, shadow_blank=all ones.
  - o_an=all ones, o_seg=7'h7F, o_dp=1, o_frame=0.
  - The first frame after reset is therefore fully dark. The first real capture occurs at the end of frame 0.
- Reset mid-frame: all outputs return to reset values immediately; scanning restarts at idx 0 after release.
- Frame period: NUM_DIGITS * 2^PRESCALE_LOG2 cycles. o_frame period equals this exactly.

Test Plan:
- Reset (NUM_DIGITS=8, PRESCALE_LOG2=4): assert rstn=0 mid-scan -> o_an=8'hFF, o_seg=7'h7F, o_dp=1, o_frame=0 immediately. After release, first 128 cycles all anodes high; o_frame pulses at cycle 1, then every 128 cycles.
- Scan order: i_value=32'h1234ABCD, brightness=15, no blank/lz. In frame 2: o_an=FE with o_seg=42 (d) for 16 cycles, then FD/08? no — FD with o_seg=31 (C), then FB with 60 (b), F7 with 08 (A), and so on, ending 7F with 4F (1). Each digit dwells exactly 16 cycles.
- Leading zeros: i_value=32'h00000050, lz=1 -> digits 7..2 anode never low; digit1 o_seg=24, digit0 o_seg=01. With i_value=0, only digit 0 lights (01). With lz=0, all digits light.
- Tear-free/freeze:
  - Change i_value mid-frame -> no change until next frame.
  - freeze=1 at cap -> display holds the old value for the next frame.
  - freeze=0 at the following cap -> new value shown.
- Blank/dp/brightness:
  - i_blank=8'h02 -> digit 1 anode stays high.
  - i_dp=8'h01 -> o_dp=0 only during digit 0.
  - brightness=3 -> anode low for presc 0..3 only (4 of 16 cycles per dwell).
  - brightness=0 -> 1 of 16 cycles.
- NUM_DIGITS=5 variant: idx wraps 4->0; o_an is 5 bits cycling 1E,1D,1B,17,0F; o_frame period 80 cycles.
